// File: rtl/alu_opdec_seq.sv
// -----------------------------------------------------------------------------
// alu_opdec_seq
//
// Registered opcode decoder that sits between instruction issue and the ALU
// datapath. It takes an opcode over a valid/ready handshake and returns a
// registered one-hot control vector. It also sets when the ALU result is
// valid: single-cycle ops complete one edge after the accept, and MUL/DIV hold
// the control vector while a latency counter runs down.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge where valid && ready are both high.
//   The producer holds its payload stable while valid is high and ready is
//   low. Input side: in_valid/in_ready with opcode as the payload. Output
//   side: out_valid/out_ready with ctrl_sig/illegal as the payload. in_ready
//   is combinational: it is 1 in IDLE and equals out_ready in DONE, so a new
//   op can enter in the same edge that the previous result leaves.
//
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   opcode     in   [OP_W]     opcode, sampled only on an accept
//   in_valid   in   opcode valid
//   in_ready   out  block can accept an opcode
//   ctrl_sig   out  [NUM_OPS]  registered one-hot op select (zero if illegal)
//   out_valid  out  op complete; ctrl_sig/illegal are valid
//   out_ready  in   consumer takes the result
//   illegal    out  accepted opcode >= NUM_OPS; qualified by out_valid
//   busy       out  multi-cycle op in progress
//   dbg_state  out  [2]  current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Optional feature, macro ALU_OPDEC_ERR_STICKY_EN:
//   err_clear  in   clears the sticky error record at the next edge
//   err_sticky out  set by the accept of an illegal opcode
//   err_opcode out  [OP_W] first offending opcode since the last clear
// -----------------------------------------------------------------------------
module alu_opdec_seq #(
  parameter int OP_W    = 5,
  parameter int NUM_OPS = 8,
  parameter int MUL_OP  = 6,
  parameter int DIV_OP  = 7,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8,
  parameter int CNT_W   = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [OP_W-1:0]    opcode,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [NUM_OPS-1:0] ctrl_sig,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               illegal,
  output logic               busy,
`ifdef ALU_OPDEC_ERR_STICKY_EN
  input  logic               err_clear,
  output logic               err_sticky,
  output logic [OP_W-1:0]    err_opcode,
`endif
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One extra bit so that NUM_OPS == 2**OP_W still compares correctly.
  localparam logic [OP_W:0]    LP_NUM_OPS  = (OP_W+1)'(NUM_OPS);
  localparam logic [OP_W-1:0]  LP_MUL_OP   = OP_W'(MUL_OP);
  localparam logic [OP_W-1:0]  LP_DIV_OP   = OP_W'(DIV_OP);
  // The accept edge is edge 1 of the latency, so the counter is loaded
  // with LAT-1 and BUSY is left on the edge where it reads 1.
  localparam logic [CNT_W-1:0] LP_MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] LP_DIV_LOAD = CNT_W'(DIV_LAT - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [NUM_OPS-1:0] r_ctrl;
  logic [NUM_OPS-1:0] w_ctrl_nxt;
  logic               r_illegal;
  logic               w_illegal_nxt;

  logic               w_accept;
  logic               w_legal;
  logic               w_multi;
  logic [NUM_OPS-1:0] w_dec;
  logic [CNT_W-1:0]   w_lat_load;

  // ---------------------------------------------------------------------------
  // Opcode decode (combinational, registered only on an accept)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_legal = ({1'b0, opcode} < LP_NUM_OPS);
    w_dec   = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (w_legal && (opcode == OP_W'(i))) begin
        w_dec[i] = 1'b1;
      end
    end
    w_multi    = w_legal && ((opcode == LP_MUL_OP) || (opcode == LP_DIV_OP));
    w_lat_load = (opcode == LP_DIV_OP) ? LP_DIV_LOAD : LP_MUL_LOAD;
  end

  assign in_ready = (r_state == ST_IDLE) ||
                    ((r_state == ST_DONE) && out_ready);
  assign w_accept = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // FSM: next state, counter and held decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_ctrl_nxt    = r_ctrl;
    w_illegal_nxt = r_illegal;

    case (r_state)
      ST_IDLE: begin
        // Accept handled below.
      end
      ST_BUSY: begin
        // <= 1 rather than == 1 keeps a corrupted count from wrapping.
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = ST_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready && !w_accept) begin
          w_state_nxt   = ST_IDLE;
          w_ctrl_nxt    = '0;
          w_illegal_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_cnt_nxt     = '0;
        w_ctrl_nxt    = '0;
        w_illegal_nxt = 1'b0;
      end
    endcase

    // An accept can only happen in IDLE or in DONE with out_ready high. In
    // DONE this retires the current result and loads the new one in the same
    // edge, so there is no bubble between ops.
    if (w_accept) begin
      w_ctrl_nxt    = w_dec;
      w_illegal_nxt = !w_legal;
      if (w_multi) begin
        w_state_nxt = ST_BUSY;
        w_cnt_nxt   = w_lat_load;
      end else begin
        w_state_nxt = ST_DONE;
        w_cnt_nxt   = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_ctrl    <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ctrl    <= w_ctrl_nxt;
      r_illegal <= w_illegal_nxt;
    end
  end

  assign ctrl_sig  = r_ctrl;
  assign illegal   = r_illegal;
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_BUSY);
  assign dbg_state = r_state;

`ifdef ALU_OPDEC_ERR_STICKY_EN
  // ---------------------------------------------------------------------------
  // Sticky illegal-opcode record. It keeps the first offender. A set in the
  // same edge as a clear wins and records the new opcode.
  // ---------------------------------------------------------------------------
  logic            r_err_sticky;
  logic [OP_W-1:0] r_err_opcode;
  logic            w_err_set;

  assign w_err_set = w_accept && !w_legal;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_err_sticky <= 1'b0;
      r_err_opcode <= '0;
    end else if (w_err_set) begin
      r_err_sticky <= 1'b1;
      if (!r_err_sticky || err_clear) begin
        r_err_opcode <= opcode;
      end
    end else if (err_clear) begin
      r_err_sticky <= 1'b0;
      r_err_opcode <= '0;
    end
  end

  assign err_sticky = r_err_sticky;
  assign err_opcode = r_err_opcode;
`endif

endmodule

// File: tb/tb_alu_opdec_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_opdec_seq
//
// Self-checking bench for alu_opdec_seq with default parameters. Inputs change
// 1 time unit after each rising edge. A negedge monitor pushes the expected
// {illegal, ctrl_sig} of every accepted opcode into exp_q and pops and compares
// it on every output transfer. Scenario tasks also make their own cycle-exact
// checks.
// -----------------------------------------------------------------------------
module tb_alu_opdec_seq;

  localparam int OP_W    = 5;
  localparam int NUM_OPS = 8;

  logic               clock;
  logic               reset_n;
  logic [OP_W-1:0]    opcode;
  logic               in_valid;
  logic               in_ready;
  logic [NUM_OPS-1:0] ctrl_sig;
  logic               out_valid;
  logic               out_ready;
  logic               illegal;
  logic               busy;
  logic [1:0]         dbg_state;
`ifdef ALU_OPDEC_ERR_STICKY_EN
  logic               err_clear;
  logic               err_sticky;
  logic [OP_W-1:0]    err_opcode;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [NUM_OPS:0] exp_q[$];
  logic [NUM_OPS:0] mon_exp;
  logic [NUM_OPS:0] mon_got;

  alu_opdec_seq #(
    .OP_W    (OP_W),
    .NUM_OPS (NUM_OPS),
    .MUL_OP  (6),
    .DIV_OP  (7),
    .MUL_LAT (3),
    .DIV_LAT (8),
    .CNT_W   (4)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .opcode     (opcode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ctrl_sig   (ctrl_sig),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .illegal    (illegal),
    .busy       (busy),
`ifdef ALU_OPDEC_ERR_STICKY_EN
    .err_clear  (err_clear),
    .err_sticky (err_sticky),
    .err_opcode (err_opcode),
`endif
    .dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard monitor (negedge, inputs are stable for the coming edge)
  // ---------------------------------------------------------------------------
  always @(negedge clock) begin
    if (reset_n) begin
      if (out_valid && out_ready) begin
        n_checks++;
        mon_got = {illegal, ctrl_sig};
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL sb_stray: out_valid with got %h and nothing expected", mon_got);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            n_errors++;
            $display("FAIL sb_result: got %h expected %h", mon_got, mon_exp);
          end
        end
      end
      if (in_valid && in_ready) begin
        mon_exp = '0;
        if (opcode < 5'd8) mon_exp[opcode[2:0]] = 1'b1;
        else               mon_exp[NUM_OPS]     = 1'b1;
        exp_q.push_back(mon_exp);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_n   = 1'b0;
    opcode    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
`ifdef ALU_OPDEC_ERR_STICKY_EN
    err_clear = 1'b0;
`endif
    #1;
    n_checks++;
    if ({ctrl_sig, out_valid, illegal, busy, in_ready} !== {8'h00, 4'b0001}) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h expected %h",
               {ctrl_sig, out_valid, illegal, busy, in_ready}, {8'h00, 4'b0001});
    end
    n_checks++;
    if (dbg_state !== 2'd0) begin
      n_errors++;
      $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
`ifdef ALU_OPDEC_ERR_STICKY_EN
    n_checks++;
    if ({err_sticky, err_opcode} !== 6'd0) begin
      n_errors++;
      $display("FAIL reset_err: got %h expected 0", {err_sticky, err_opcode});
    end
`endif
    step();
    step();
    reset_n = 1'b1;
    step();

    // DIV accepted, then reset lands in cycle 3 of 8.
    opcode   = 5'd7;
    in_valid = 1'b1;
    step();            // edge 1 (accept)
    in_valid = 1'b0;
    step();            // edge 2
    step();            // edge 3
    n_checks++;
    if ({busy, ctrl_sig} !== {1'b1, 8'h80}) begin
      n_errors++;
      $display("FAIL div_busy_before_reset: got %h expected %h", {busy, ctrl_sig}, {1'b1, 8'h80});
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({ctrl_sig, out_valid, illegal, busy, in_ready} !== {8'h00, 4'b0001}) begin
      n_errors++;
      $display("FAIL reset_mid_div: got %h expected %h",
               {ctrl_sig, out_valid, illegal, busy, in_ready}, {8'h00, 4'b0001});
    end
    exp_q.delete();    // the aborted DIV produces no result
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        n_errors++;
        $display("FAIL post_reset_idle: cycle %0d got %b expected 01", k, {out_valid, in_ready});
      end
      step();
    end
  endtask

  task automatic test_and();
    opcode    = 5'd2;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL and_in_ready: got %b expected 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, illegal, busy, ctrl_sig} !== {3'b100, 8'h04}) begin
      n_errors++;
      $display("FAIL and_result: got %h expected %h", {out_valid, illegal, busy, ctrl_sig}, {3'b100, 8'h04});
    end
    step();
    n_checks++;
    if ({out_valid, ctrl_sig, dbg_state} !== {1'b0, 8'h00, 2'd0}) begin
      n_errors++;
      $display("FAIL and_back_to_idle: got %h expected %h", {out_valid, ctrl_sig, dbg_state}, {1'b0, 8'h00, 2'd0});
    end
  endtask

  task automatic test_mul();
    opcode    = 5'd6;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();            // edge 1 (accept)
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({busy, in_ready, out_valid, ctrl_sig} !== {3'b100, 8'h40}) begin
        n_errors++;
        $display("FAIL mul_busy: cycle %0d got %h expected %h", k,
                 {busy, in_ready, out_valid, ctrl_sig}, {3'b100, 8'h40});
      end
      step();          // edges 2, 3
    end
    n_checks++;
    if ({busy, out_valid, illegal, ctrl_sig} !== {3'b010, 8'h40}) begin
      n_errors++;
      $display("FAIL mul_done: got %h expected %h", {busy, out_valid, illegal, ctrl_sig}, {3'b010, 8'h40});
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL mul_single_result: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int ops[4] = '{0, 1, 4, 5};
    logic [7:0] e;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      opcode   = 5'(ops[i]);
      in_valid = 1'b1;
      step();
      e = '0;
      e[ops[i]] = 1'b1;
      n_checks++;
      if ({out_valid, ctrl_sig} !== {1'b1, e}) begin
        n_errors++;
        $display("FAIL b2b_op%0d: got %h expected %h", i, {out_valid, ctrl_sig}, {1'b1, e});
      end
    end
    in_valid = 1'b0;
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_drain: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    opcode    = 5'd3;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      opcode = 5'($urandom_range(0, 31));   // ignored while stalled
      #1;
      n_checks++;
      if ({in_ready, out_valid, ctrl_sig} !== {2'b01, 8'h08}) begin
        n_errors++;
        $display("FAIL bp_hold: cycle %0d got %h expected %h", k,
                 {in_ready, out_valid, ctrl_sig}, {2'b01, 8'h08});
      end
      step();
    end
    opcode    = 5'd1;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_release_ready: got %b expected 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, ctrl_sig} !== {1'b1, 8'h02}) begin
      n_errors++;
      $display("FAIL bp_next_op: got %h expected %h", {out_valid, ctrl_sig}, {1'b1, 8'h02});
    end
    step();
  endtask

  task automatic test_illegal();
    opcode    = 5'd20;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    n_checks++;
    if ({out_valid, illegal, ctrl_sig} !== {2'b11, 8'h00}) begin
      n_errors++;
      $display("FAIL illegal_20: got %h expected %h", {out_valid, illegal, ctrl_sig}, {2'b11, 8'h00});
    end
`ifdef ALU_OPDEC_ERR_STICKY_EN
    n_checks++;
    if ({err_sticky, err_opcode} !== {1'b1, 5'd20}) begin
      n_errors++;
      $display("FAIL err_first: got %h expected %h", {err_sticky, err_opcode}, {1'b1, 5'd20});
    end
`endif
    opcode = 5'd31;
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, illegal, ctrl_sig} !== {2'b11, 8'h00}) begin
      n_errors++;
      $display("FAIL illegal_31: got %h expected %h", {out_valid, illegal, ctrl_sig}, {2'b11, 8'h00});
    end
`ifdef ALU_OPDEC_ERR_STICKY_EN
    n_checks++;
    if ({err_sticky, err_opcode} !== {1'b1, 5'd20}) begin
      n_errors++;
      $display("FAIL err_keep_first: got %h expected %h", {err_sticky, err_opcode}, {1'b1, 5'd20});
    end
    err_clear = 1'b1;
`endif
    step();
    n_checks++;
    if ({out_valid, illegal} !== 2'b00) begin
      n_errors++;
      $display("FAIL illegal_clear: got %b expected 00", {out_valid, illegal});
    end
`ifdef ALU_OPDEC_ERR_STICKY_EN
    err_clear = 1'b0;
    n_checks++;
    if ({err_sticky, err_opcode} !== 6'd0) begin
      n_errors++;
      $display("FAIL err_cleared: got %h expected 0", {err_sticky, err_opcode});
    end
`endif
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      opcode    = 5'($urandom_range(0, 11));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      n_checks++;
      if ((ctrl_sig & (ctrl_sig - 8'd1)) !== 8'h00) begin
        n_errors++;
        $display("FAIL rand_onehot: got %h expected at most one bit", ctrl_sig);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL rand_drain: got %0d pending expected 0", exp_q.size());
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_and();
    test_mul();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_random();
    step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL final_queue: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
